// File: rtl/async_tx_bridge.sv
// async_tx_bridge: clocked valid/ready FIFO feeding a 4-phase bundled-data async pipeline stage
module async_tx_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic                         req_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  input  logic                         ack_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         proto_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(SETUP_CYCLES+1);
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_RTZ} state_t;
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          count_q, count_d;
  logic [SW-1:0]          setup_q, setup_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   req_q, req_d, err_q, err_d;
  logic                   push, pop, ack_s;
  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign ready_o     = count_q < CW'(DEPTH);
  assign push        = valid_i & ready_o;
  assign pop         = (state_q == WAIT_ACK) & ack_s;
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign count_o     = count_q;
  assign proto_err_o = err_q;
  assign wr_d    = push ? wr_q + AW'(1) : wr_q;
  assign rd_d    = pop ? rd_q + AW'(1) : rd_q;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign err_d   = err_q | (ack_s & (state_q == IDLE || state_q == SETUP));
  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (count_q != '0) begin
        data_d  = mem_q[rd_q];
        setup_d = SW'(SETUP_CYCLES);
        state_d = SETUP;
      end
      SETUP: begin
        setup_d = setup_q - SW'(1);
        if (setup_q == SW'(1)) begin
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: if (ack_s) begin
        req_d   = 1'b0;
        state_d = WAIT_RTZ;
      end
      WAIT_RTZ: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      setup_q <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      sync_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_i};
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: tb/tb_async_tx_bridge.sv
// tb_async_tx_bridge: directed checks of the async_tx_bridge handshake, FIFO and protocol flag
module tb_async_tx_bridge;
  logic        clk_i = 1'b0, rst_ni = 1'b1, valid_i = 1'b0, ack_i = 1'b0;
  logic        ready_o, req_o, proto_err_o;
  logic [31:0] data_i = '0, data_o;
  logic [1:0]  count_o;
  logic        auto_ack = 1'b1;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] log_q [$];
  logic        req_prev = 1'b0;
  logic [31:0] data_prev = '0;
  async_tx_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .count_o(count_o), .proto_err_o(proto_err_o)
  );
  always #5 clk_i = ~clk_i;
  // Async stage behaves as a C-element: ack follows req after 3 ns.
  always @(req_o) if (auto_ack) begin
    #3;
    ack_i = req_o;
  end
  always @(negedge clk_i) begin
    if (req_o && !req_prev) begin
      log_q.push_back(data_o);
      chk("bundle_hold", data_prev, data_o);
    end
    req_prev  = req_o;
    data_prev = data_o;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [31:0] w);
    logic r;
    valid_i = 1'b1;
    data_i  = w;
    for (int i = 0; i < 100; i++) begin
      r = ready_o;
      step();
      if (r) break;
    end
    valid_i = 1'b0;
    chk("push_accepted", r, 1'b1);
  endtask
  task automatic wait_req(input logic lvl);
    for (int i = 0; i < 100; i++) begin
      if (req_o == lvl) break;
      step();
    end
    chk("wait_req", req_o, lvl);
  endtask
  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (count_o == 0 && req_o == 1'b0) break;
      step();
    end
    repeat (8) step();
    chk("drain_count", count_o, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] exp4 [10];
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_req", req_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_err", proto_err_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();
    chk("rst_ready", ready_o, 1);
    // single transfer with exact edge timing
    log_q.delete();
    valid_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    step();
    valid_i = 1'b0;
    chk("e0_count", count_o, 1);
    chk("e0_data", data_o, 0);
    step();
    chk("e1_data", data_o, 32'hDEADBEEF);
    chk("e1_req", req_o, 0);
    step();
    chk("e2_req", req_o, 1);
    step();
    step();
    chk("e4_req", req_o, 1);
    step();
    chk("e5_req", req_o, 0);
    chk("e5_count", count_o, 0);
    repeat (6) step();
    chk("single_err", proto_err_o, 0);
    chk("single_data_held", data_o, 32'hDEADBEEF);
    chk("single_log", log_q[0], 32'hDEADBEEF);
    // back-to-back with a full FIFO
    log_q.delete();
    push(32'h1);
    push(32'h2);
    chk("full_ready", ready_o, 0);
    chk("full_count", count_o, 2);
    push(32'h3);
    drain();
    chk("b2b_n", log_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("b2b_order", log_q[i], i + 1);
    // simultaneous push and pop, then a stream across several pointer wraps
    log_q.delete();
    push(32'hA0);
    repeat (4) step();
    chk("pp_req_before", req_o, 1);
    chk("pp_count_before", count_o, 1);
    valid_i = 1'b1;
    data_i  = 32'hB0;
    step();
    valid_i = 1'b0;
    chk("pp_req_after", req_o, 0);
    chk("pp_count_after", count_o, 1);
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    drain();
    exp4[0] = 32'hA0;
    exp4[1] = 32'hB0;
    for (int i = 0; i < 8; i++) exp4[i+2] = 32'h10 + i;
    chk("wrap_n", log_q.size(), 10);
    for (int i = 0; i < 10; i++) chk("wrap_order", log_q[i], exp4[i]);
    // ack pulse while idle
    log_q.delete();
    auto_ack = 1'b0;
    chk("pre_pulse_err", proto_err_o, 0);
    ack_i = 1'b1;
    repeat (3) step();
    ack_i = 1'b0;
    repeat (3) step();
    chk("pulse_err", proto_err_o, 1);
    auto_ack = 1'b1;
    push(32'h55);
    drain();
    chk("pulse_xfer", log_q[0], 32'h55);
    chk("pulse_err_sticky", proto_err_o, 1);
    // slow pipeline holding ack high
    log_q.delete();
    auto_ack = 1'b0;
    push(32'h77);
    push(32'h88);
    wait_req(1'b1);
    ack_i = 1'b1;
    wait_req(1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("slow_req", req_o, 0);
      chk("slow_data", data_o, 32'h77);
    end
    chk("slow_count", count_o, 1);
    auto_ack = 1'b1;
    ack_i = 1'b0;
    drain();
    chk("slow_n", log_q.size(), 2);
    chk("slow_w0", log_q[0], 32'h77);
    chk("slow_w1", log_q[1], 32'h88);
    // reset in the middle of WAIT_ACK
    auto_ack = 1'b0;
    push(32'hA1);
    push(32'hA2);
    wait_req(1'b1);
    chk("mid_count", count_o, 2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", req_o, 0);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_err", proto_err_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_req", req_o, 0);
    end
    log_q.delete();
    auto_ack = 1'b1;
    push(32'hB1);
    drain();
    chk("post_rst_xfer", log_q[0], 32'hB1);
    chk("post_rst_n", log_q.size(), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
